// File: rtl/rxepktctl_pkg.sv
// Shared encodings for the RX packet check sequencer.
// State and reason codes are also used by the packet buffer and stats slave.
package rxepktctl_pkg;

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_IDLE,
    ST_ACTIVE,
    ST_FINISH
  } state_t;

  typedef enum logic [2:0] {
    RSN_NONE = 3'd0,
    RSN_CRC  = 3'd1,
    RSN_RUNT = 3'd2,
    RSN_MAC  = 3'd3,
    RSN_IP   = 3'd4
  } reason_t;

  localparam int NSTAT = 6;

  // Several causes may hold at once; the highest-priority one wins.
  function automatic reason_t pick_reason(
    input logic crc,
    input logic runt,
    input logic mac,
    input logic ip
  );
    reason_t r;
    if (crc)       r = RSN_CRC;
    else if (runt) r = RSN_RUNT;
    else if (mac)  r = RSN_MAC;
    else if (ip)   r = RSN_IP;
    else           r = RSN_NONE;
    return r;
  endfunction

endpackage

// File: rtl/rxestatcnt.sv
// Saturating statistics counter with clear and increment.
// Clear wins over a same-cycle increment.
module rxestatcnt #(
  parameter int CW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rxepktctl.sv
// Per-packet sequencer for the RX check chain: latches checker
// enables, collects sticky errors, issues a verdict, keeps statistics.
module rxepktctl #(
  parameter int MINLEN = 64,
  parameter int LGLEN  = 11,
  parameter int CW     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_v,
  input  logic             i_cfg_crc_en,
  input  logic             i_cfg_mac_en,
  input  logic             i_cfg_ip_en,
  input  logic             i_crc_err,
  input  logic             i_mac_err,
  input  logic             i_ip_err,
  input  logic             i_clr_stats,
  output logic             o_crc_en,
  output logic             o_mac_en,
  output logic             o_ip_en,
  output logic             o_done,
  output logic             o_drop,
  output logic [2:0]       o_reason,
  output logic [LGLEN-1:0] o_len,
  output logic [CW-1:0]    o_npkts,
  output logic [CW-1:0]    o_ndrop,
  output logic [CW-1:0]    o_ncrc,
  output logic [CW-1:0]    o_nrunt,
  output logic [CW-1:0]    o_nmac,
  output logic [CW-1:0]    o_nip
);

  import rxepktctl_pkg::*;

  localparam logic [31:0] MINU = 32'(MINLEN);

  state_t            r_state;
  state_t            w_state_n;
  logic [2:0]        r_en;
  logic [2:0]        w_en_n;
  logic [2:0]        r_err;
  logic [2:0]        w_err_n;
  logic [2:0]        w_err_s;
  logic [LGLEN-1:0]  r_len;
  logic [LGLEN-1:0]  w_len_n;
  logic              w_start;
  logic              w_fin;
  logic              w_runt;
  reason_t           w_rsn;
  logic              r_done;
  logic              r_drop;
  reason_t           r_reason;
  logic [LGLEN-1:0]  r_olen;

  // Error bit order is {crc, mac, ip}, matching r_en.
  assign w_err_s = r_err
                 | ({i_crc_err, i_mac_err, i_ip_err} & r_en);

  always_comb begin
    w_state_n = r_state;
    w_en_n    = r_en;
    w_err_n   = r_err;
    w_len_n   = r_len;
    w_start   = 1'b0;
    w_fin     = 1'b0;
    unique case (r_state)
      ST_SKIP: begin
        if (!i_v) w_state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_v) begin
          w_state_n = ST_ACTIVE;
          w_start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_err_n = w_err_s;
        if (i_v) begin
          if (!(&r_len)) w_len_n = r_len + LGLEN'(1);
        end else begin
          w_state_n = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_fin   = 1'b1;
        w_err_n = w_err_s;
        if (i_v) begin
          w_state_n = ST_ACTIVE;
          w_start   = 1'b1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_SKIP;
    endcase
    if (w_start) begin
      w_en_n  = {i_cfg_crc_en, i_cfg_mac_en, i_cfg_ip_en};
      w_len_n = LGLEN'(1);
      w_err_n = '0;
    end
  end

  // Verdict uses this cycle's errors too, so the last byte's error counts.
  assign w_runt = (MINLEN != 0) && (32'(r_len) < MINU);
  assign w_rsn  = pick_reason(w_err_s[2], w_runt,
                              w_err_s[1], w_err_s[0]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_SKIP;
      r_en     <= '0;
      r_err    <= '0;
      r_len    <= '0;
      r_done   <= 1'b0;
      r_drop   <= 1'b0;
      r_reason <= RSN_NONE;
      r_olen   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_en     <= w_en_n;
      r_err    <= w_err_n;
      r_len    <= w_len_n;
      r_done   <= w_fin;
      r_drop   <= w_fin && (w_rsn != RSN_NONE);
      r_reason <= w_fin ? w_rsn : RSN_NONE;
      r_olen   <= w_fin ? r_len : '0;
    end
  end

  assign o_crc_en = r_en[2];
  assign o_mac_en = r_en[1];
  assign o_ip_en  = r_en[0];
  assign o_done   = r_done;
  assign o_drop   = r_drop;
  assign o_reason = r_reason;
  assign o_len    = r_olen;

  logic [NSTAT-1:0] w_inc;
  logic [CW-1:0]    w_cnt [NSTAT];

  assign w_inc[0] = r_done;
  assign w_inc[1] = r_drop;
  assign w_inc[2] = (r_reason == RSN_CRC);
  assign w_inc[3] = (r_reason == RSN_RUNT);
  assign w_inc[4] = (r_reason == RSN_MAC);
  assign w_inc[5] = (r_reason == RSN_IP);

  for (genvar g = 0; g < NSTAT; g++) begin : g_stat
    rxestatcnt #(.CW(CW)) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (i_clr_stats),
      .i_inc   (w_inc[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  assign o_npkts = w_cnt[0];
  assign o_ndrop = w_cnt[1];
  assign o_ncrc  = w_cnt[2];
  assign o_nrunt = w_cnt[3];
  assign o_nmac  = w_cnt[4];
  assign o_nip   = w_cnt[5];

endmodule
